// File: rtl/tick_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tick_scheduler
//  Purpose  : One shared prescaler divides the system clock down to a base
//             tick. Four channels each divide the base tick by their own
//             programmable period. Each channel produces a one-cycle enable
//             pulse and a square wave that toggles on every pulse. A
//             valid/ready port reprograms one channel's period. The new
//             period is applied on a base-tick boundary, so a channel never
//             produces a shortened interval.
//
//  Ports    : clk_50MHz  in   system clock, rising edge
//             rst        in   synchronous, active-high reset
//             ch_en      in   [3:0] per-channel run enable
//             cfg_valid  in   configuration request
//             cfg_ch     in   [1:0] target channel
//             cfg_period in   [PERIOD_W-1:0] new period in base ticks (0 = stop)
//             cfg_ready  out  configuration port idle
//             cfg_done   out  one-cycle pulse, cycle after the new period applied
//             base_tick  out  one-cycle pulse every PRESCALE clocks
//             tick       out  [3:0] per-channel one-cycle enable pulse
//             sq         out  [3:0] per-channel square wave
//
//  Revision : 1.0  initial release
// ============================================================================
module tick_scheduler #(
    parameter int CLK_HZ     = 50000000,
    parameter int BASE_HZ    = 1000,
    parameter int PERIOD_W   = 16,
    parameter int RST_PERIOD = 1000
) (
    input  logic                clk_50MHz,
    input  logic                rst,
    input  logic [3:0]          ch_en,
    input  logic                cfg_valid,
    input  logic [1:0]          cfg_ch,
    input  logic [PERIOD_W-1:0] cfg_period,
    output logic                cfg_ready,
    output logic                cfg_done,
    output logic                base_tick,
    output logic [3:0]          tick,
    output logic [3:0]          sq
);

    // CLK_HZ must be an integer multiple (at least 2x) of BASE_HZ.
    localparam int c_PRESCALE = CLK_HZ / BASE_HZ;
    localparam int c_CNT_W    = (c_PRESCALE > 1) ? $clog2(c_PRESCALE) : 1;

    localparam logic [c_CNT_W-1:0]  c_PRE_LAST   = c_CNT_W'(c_PRESCALE - 1);
    localparam logic [c_CNT_W-1:0]  c_PRE_ONE    = c_CNT_W'(1);
    localparam logic [PERIOD_W-1:0] c_RST_PERIOD = PERIOD_W'(RST_PERIOD);
    localparam logic [PERIOD_W-1:0] c_PER_ONE    = PERIOD_W'(1);

    // ------------------------------------------------------------------------
    // Prescaler
    // The counter runs 0..PRESCALE-1. base_tick is registered from the wrap
    // condition, so it is high in the cycle after the counter showed
    // PRESCALE-1. The first pulse therefore lands PRESCALE cycles after reset.
    // ------------------------------------------------------------------------
    logic [c_CNT_W-1:0] r_pre_cnt;
    logic               r_base_tick;
    logic               w_pre_wrap;

    assign w_pre_wrap = (r_pre_cnt == c_PRE_LAST);

    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            r_pre_cnt   <= '0;
            r_base_tick <= 1'b0;
        end else begin
            r_base_tick <= w_pre_wrap;
            r_pre_cnt   <= w_pre_wrap ? '0 : (r_pre_cnt + c_PRE_ONE);
        end
    end

    assign base_tick = r_base_tick;

    // ------------------------------------------------------------------------
    // Configuration FSM
    // A request is captured in IDLE. The write waits in PEND for the next
    // base-tick cycle, so a channel count is only ever restarted on the same
    // grid it counts on. DONE produces the acknowledge pulse.
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PEND = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [1:0]          r_cfg_ch;
    logic [PERIOD_W-1:0] r_cfg_period;
    logic                w_accept;
    logic                w_apply;

    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cfg_ch     <= '0;
            r_cfg_period <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_cfg_ch     <= cfg_ch;
                r_cfg_period <= cfg_period;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_apply     = 1'b0;
        cfg_ready   = 1'b0;
        cfg_done    = 1'b0;
        case (r_state)
            S_IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_PEND;
                end
            end
            S_PEND: begin
                // cfg_valid is deliberately ignored here.
                if (r_base_tick) begin
                    w_apply     = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                cfg_done    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Channels
    // The count advances only in base-tick cycles. A channel that is disabled
    // or has period 0 holds its count at zero, so re-enabling it starts a full
    // period. An apply to this channel takes priority over a natural expiry
    // in the same cycle: the pulse is dropped, sq keeps its level, and the
    // count restarts from zero under the new period.
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < 4; gi++) begin : g_ch
        logic [PERIOD_W-1:0] r_period;
        logic [PERIOD_W-1:0] r_count;
        logic                r_sq;
        logic                w_apply_here;
        logic                w_run;
        logic                w_expire;

        assign w_apply_here = w_apply && (r_cfg_ch == 2'(gi));
        assign w_run        = ch_en[gi] && (r_period != '0);
        // r_count < r_period always holds, so period-1 cannot underflow
        // while w_run is true.
        assign w_expire     = r_base_tick && w_run &&
                              (r_count == (r_period - c_PER_ONE));

        assign tick[gi] = w_expire && !w_apply_here;
        assign sq[gi]   = r_sq;

        always_ff @(posedge clk_50MHz) begin
            if (rst) begin
                r_period <= c_RST_PERIOD;
                r_count  <= '0;
                r_sq     <= 1'b0;
            end else if (w_apply_here) begin
                r_period <= r_cfg_period;
                r_count  <= '0;
            end else if (r_base_tick) begin
                if (!w_run) begin
                    r_count <= '0;
                end else if (w_expire) begin
                    r_count <= '0;
                    r_sq    <= ~r_sq;
                end else begin
                    r_count <= r_count + c_PER_ONE;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tick_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_tick_scheduler
//  Purpose  : Self-checking bench for tick_scheduler with PRESCALE = 10 and
//             a reset period of 3. A timeline table covers the start-up and
//             configuration corner cases. Hand-written sequences cover
//             stopping a channel, gating a channel, and reset during a
//             pending write. A randomized run follows. A reference model
//             checks every cycle. The model tracks the base ticks remaining
//             per channel and derives base-tick timing from the cycle index.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tick_scheduler;

    localparam int PS = 10;   // CLK_HZ / BASE_HZ

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  ch_en = 4'h0;
    logic        cfg_valid = 1'b0;
    logic [1:0]  cfg_ch = 2'd0;
    logic [15:0] cfg_period = 16'd0;
    logic        cfg_ready, cfg_done, base_tick;
    logic [3:0]  tick, sq;

    always #5 clk = ~clk;

    tick_scheduler #(
        .CLK_HZ     (20),
        .BASE_HZ    (2),
        .PERIOD_W   (16),
        .RST_PERIOD (3)
    ) dut (
        .clk_50MHz  (clk),
        .rst        (rst),
        .ch_en      (ch_en),
        .cfg_valid  (cfg_valid),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .cfg_ready  (cfg_ready),
        .cfg_done   (cfg_done),
        .base_tick  (base_tick),
        .tick       (tick),
        .sq         (sq)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Requested inputs for the next cycle, and sampled outputs of the last one
    logic        d_rst = 1'b1;
    logic [3:0]  d_en = 4'h0;
    logic        d_valid = 1'b0;
    logic [1:0]  d_ch = 2'd0;
    logic [15:0] d_per = 16'd0;
    logic        s_bt, s_rdy, s_done;
    logic [3:0]  s_tick, s_sq;
    int          cur_k = -1;

    // Reference model state
    bit       m_live = 1'b0;
    int       m_k = 0;
    int       m_period [4];
    int       m_rem [4];        // enabled base ticks left until the next pulse
    bit [3:0] m_sq;
    bit       m_pend, m_done;
    int       m_pch, m_pper;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cur_k);
        end
    endtask

    task automatic model_reset();
        m_live = 1'b1;
        m_k    = 0;
        for (int i = 0; i < 4; i++) begin
            m_period[i] = 3;
            m_rem[i]    = 3;
        end
        m_sq   = 4'h0;
        m_pend = 1'b0;
        m_done = 1'b0;
        m_pch  = 0;
        m_pper = 0;
    endtask

    task automatic model_step();
        bit       bt, apply, rdy;
        bit [3:0] etick;
        if (d_rst) begin
            cur_k = -1;
            model_reset();
            return;
        end
        if (!m_live) return;
        cur_k = m_k;
        bt    = (m_k > 0) && (m_k % PS == 0);
        apply = m_pend && bt;
        rdy   = !m_pend && !m_done;
        for (int i = 0; i < 4; i++)
            etick[i] = bt && d_en[i] && (m_period[i] != 0) && (m_rem[i] == 1) &&
                       !(apply && m_pch == i);
        check("model", 32'({s_bt, s_tick, s_sq, s_rdy, s_done}),
                       32'({bt, etick, m_sq, rdy, m_done}));
        for (int i = 0; i < 4; i++) begin
            if (apply && m_pch == i) begin
                m_period[i] = m_pper;
                m_rem[i]    = m_pper;
            end else if (bt) begin
                if (!d_en[i] || m_period[i] == 0) m_rem[i] = m_period[i];
                else if (m_rem[i] == 1) begin
                    m_sq[i]  = ~m_sq[i];
                    m_rem[i] = m_period[i];
                end else m_rem[i] = m_rem[i] - 1;
            end
        end
        if (apply) m_pend = 1'b0;
        else if (rdy && d_valid) begin
            m_pend = 1'b1;
            m_pch  = int'(d_ch);
            m_pper = int'(d_per);
        end
        m_done = apply;
        m_k++;
    endtask

    task automatic run_cycle();
        @(posedge clk);
        #1;
        rst        = d_rst;
        ch_en      = d_en;
        cfg_valid  = d_valid;
        cfg_ch     = d_ch;
        cfg_period = d_per;
        #2;
        s_bt   = base_tick;
        s_tick = tick;
        s_sq   = sq;
        s_rdy  = cfg_ready;
        s_done = cfg_done;
        model_step();
    endtask

    // Timeline vectors: inputs applied in cycle k, outputs expected in cycle k
    typedef struct {
        int          k;
        logic [3:0]  en;
        logic        v;
        logic [1:0]  ch;
        logic [15:0] per;
        logic        bt;
        logic [3:0]  tk;
        logic [3:0]  sq;
        logic        rdy;
        logic        dn;
    } vec_t;

    vec_t vt[$];

    task automatic add(input int k, input logic v, input logic [1:0] ch, input logic [15:0] per,
                       input logic bt, input logic [3:0] tk, input logic [3:0] sqv,
                       input logic rdy, input logic dn);
        vec_t e;
        e.k = k; e.en = 4'hF; e.v = v; e.ch = ch; e.per = per;
        e.bt = bt; e.tk = tk; e.sq = sqv; e.rdy = rdy; e.dn = dn;
        vt.push_back(e);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  idx;
        int  seen;
        int  apply_k;
        int  first_k;
        int  b_k;
        int  first_tick [4];
        logic sq1_ref;

        //   k   v  ch  per  bt  tick     sq       rdy dn
        add( 0, 0, 0, 0,  0, 4'b0000, 4'b0000, 1, 0);
        add( 9, 0, 0, 0,  0, 4'b0000, 4'b0000, 1, 0);
        add(10, 0, 0, 0,  1, 4'b0000, 4'b0000, 1, 0);
        add(20, 0, 0, 0,  1, 4'b0000, 4'b0000, 1, 0);
        add(29, 0, 0, 0,  0, 4'b0000, 4'b0000, 1, 0);
        add(30, 0, 0, 0,  1, 4'b1111, 4'b0000, 1, 0);
        add(31, 0, 0, 0,  0, 4'b0000, 4'b1111, 1, 0);
        add(35, 1, 2, 1,  0, 4'b0000, 4'b1111, 1, 0);   // ch2 -> period 1
        add(36, 0, 0, 0,  0, 4'b0000, 4'b1111, 0, 0);
        add(40, 0, 0, 0,  1, 4'b0000, 4'b1111, 0, 0);   // apply
        add(41, 0, 0, 0,  0, 4'b0000, 4'b1111, 0, 1);
        add(42, 0, 0, 0,  0, 4'b0000, 4'b1111, 1, 0);
        add(50, 0, 0, 0,  1, 4'b0100, 4'b1111, 1, 0);
        add(51, 0, 0, 0,  0, 4'b0000, 4'b1011, 1, 0);
        add(52, 1, 0, 2,  0, 4'b0000, 4'b1011, 1, 0);   // ch0 -> period 2, apply at 60
        add(60, 0, 0, 0,  1, 4'b1110, 4'b1011, 0, 0);   // ch0 expiry suppressed
        add(61, 0, 0, 0,  0, 4'b0000, 4'b0101, 0, 1);
        add(62, 0, 0, 0,  0, 4'b0000, 4'b0101, 1, 0);
        add(70, 0, 0, 0,  1, 4'b0100, 4'b0101, 1, 0);
        add(71, 0, 0, 0,  0, 4'b0000, 4'b0001, 1, 0);
        add(80, 0, 0, 0,  1, 4'b0101, 4'b0001, 1, 0);
        add(81, 0, 0, 0,  0, 4'b0000, 4'b0100, 1, 0);
        add(90, 0, 0, 0,  1, 4'b1110, 4'b0100, 1, 0);
        add(91, 0, 0, 0,  0, 4'b0000, 4'b1010, 1, 0);

        d_rst = 1'b1;
        run_cycle();
        run_cycle();
        d_rst = 1'b0;
        d_en  = 4'hF;

        idx = 0;
        for (int k = 0; k < 96; k++) begin
            d_valid = 1'b0;
            if (idx < vt.size() && vt[idx].k == k) begin
                d_en    = vt[idx].en;
                d_valid = vt[idx].v;
                d_ch    = vt[idx].ch;
                d_per   = vt[idx].per;
            end
            run_cycle();
            if (idx < vt.size() && vt[idx].k == k) begin
                check($sformatf("vec%0d_base_tick", k), 32'(s_bt),   32'(vt[idx].bt));
                check($sformatf("vec%0d_tick", k),      32'(s_tick), 32'(vt[idx].tk));
                check($sformatf("vec%0d_sq", k),        32'(s_sq),   32'(vt[idx].sq));
                check($sformatf("vec%0d_cfg_ready", k), 32'(s_rdy),  32'(vt[idx].rdy));
                check($sformatf("vec%0d_cfg_done", k),  32'(s_done), 32'(vt[idx].dn));
                idx++;
            end
        end
        d_valid = 1'b0;

        // Stop channel 1 with period 0, then restart it with period 2
        d_valid = 1'b1; d_ch = 2'd1; d_per = 16'd0;
        run_cycle();
        d_valid = 1'b0;
        seen = 0;
        for (int n = 0; n < 15 && seen == 0; n++) begin
            run_cycle();
            if (s_done) seen = 1;
        end
        check("stop_done_seen", 32'(seen), 32'd1);
        sq1_ref = s_sq[1];
        seen = 0;
        for (int n = 0; n < 80; n++) begin
            run_cycle();
            if (s_tick[1] || s_sq[1] !== sq1_ref) seen = 1;
        end
        check("stop_ch1_quiet", 32'(seen), 32'd0);

        d_valid = 1'b1; d_ch = 2'd1; d_per = 16'd2;
        run_cycle();
        d_valid = 1'b0;
        seen = 0;
        for (int n = 0; n < 15 && seen == 0; n++) begin
            run_cycle();
            if (s_done) seen = 1;
        end
        check("restart_done_seen", 32'(seen), 32'd1);
        apply_k = cur_k - 1;
        first_k = -1;
        for (int n = 0; n < 40 && first_k < 0; n++) begin
            run_cycle();
            if (s_tick[1]) first_k = cur_k;
        end
        check("restart_ch1_tick_cycle", 32'(first_k), 32'(apply_k + 2 * PS));

        // Gate channel 3 off for 25 cycles, re-enable just after a base tick
        seen = 0;
        for (int n = 0; n < 12 && seen == 0; n++) begin
            run_cycle();
            if (s_bt) seen = 1;
        end
        check("gate_bt_seen", 32'(seen), 32'd1);
        b_k = cur_k;
        for (int n = 0; n < 5; n++) run_cycle();
        d_en = 4'b0111;
        seen = 0;
        for (int n = 0; n < 25; n++) begin
            run_cycle();
            if (s_tick[3]) seen = 1;
        end
        check("gate_ch3_quiet", 32'(seen), 32'd0);
        d_en = 4'hF;
        first_k = -1;
        for (int n = 0; n < 40 && first_k < 0; n++) begin
            run_cycle();
            if (s_tick[3]) first_k = cur_k;
        end
        check("gate_ch3_tick_cycle", 32'(first_k), 32'(b_k + 6 * PS));

        // Reset while a write is pending
        d_valid = 1'b1; d_ch = 2'd0; d_per = 16'd5;
        run_cycle();
        d_valid = 1'b0;
        run_cycle();
        check("pend_ready_low", 32'(s_rdy), 32'd0);
        d_rst = 1'b1;
        run_cycle();
        d_rst = 1'b0;
        run_cycle();
        check("rst_ready",  32'(s_rdy),  32'd1);
        check("rst_done",   32'(s_done), 32'd0);
        check("rst_outs",   32'({s_bt, s_tick, s_sq}), 32'd0);
        first_k = -1;
        seen = 0;
        for (int i = 0; i < 4; i++) first_tick[i] = -1;
        for (int n = 0; n < 40; n++) begin
            run_cycle();
            if (s_bt && first_k < 0) first_k = cur_k;
            if (s_done) seen = 1;
            for (int i = 0; i < 4; i++)
                if (s_tick[i] && first_tick[i] < 0) first_tick[i] = cur_k;
        end
        check("rst_first_bt", 32'(first_k), 32'(PS));
        check("rst_no_done",  32'(seen),    32'd0);
        for (int i = 0; i < 4; i++)
            check($sformatf("rst_first_tick%0d", i), 32'(first_tick[i]), 32'(3 * PS));

        // Randomized traffic, checked every cycle by the model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 63) == 0) d_en[$urandom_range(0, 3)] ^= 1'b1;
            d_valid = ($urandom_range(0, 7) == 0);
            d_ch    = 2'($urandom_range(0, 3));
            d_per   = 16'($urandom_range(0, 4));
            d_rst   = ($urandom_range(0, 499) == 0);
            run_cycle();
        end
        d_rst   = 1'b0;
        d_valid = 1'b0;
        run_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
